// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for pipelined_adder: valid/ready on the operand
// side, valid/ready on the result side. The adder takes the slave modport.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with the carry chain split into STAGES chunks and a global stall.
// Optional macro PIPELINED_ADDER_SAT_EN clamps overflowing results to the signed limit.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_adder_if.slave   bus
);
    localparam int C = WIDTH / STAGES;

    logic                advance;

    // Level k holds operands plus chunks [0, k) already summed; level 0 is the capture register.
    logic [STAGES-1:0]   vld;
    logic [STAGES-1:0]   cy_q;
    logic [WIDTH-1:0]    a_q   [STAGES];
    logic [WIDTH-1:0]    b_q   [STAGES];
    logic [WIDTH-1:0]    sum_q [STAGES];

    logic [C:0]          add_res [STAGES];
    logic [WIDTH-1:0]    sum_nxt [STAGES];
    logic [WIDTH-1:0]    sum_fin;
    logic                ovf_nxt;

    logic                out_vld;
    logic [WIDTH-1:0]    sum_o;
    logic                cout_o;
    logic                ovf_o;

    assign advance       = !out_vld || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_vld;
    assign bus.sum       = sum_o;
    assign bus.cout      = cout_o;
    assign bus.ovf       = ovf_o;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            add_res[k] = {1'b0, a_q[k][k*C +: C]}
                       + {1'b0, b_q[k][k*C +: C]}
                       + {{C{1'b0}}, cy_q[k]};
            sum_nxt[k] = sum_q[k];
            sum_nxt[k][k*C +: C] = add_res[k][C-1:0];
        end
    end

    always_comb begin
        ovf_nxt = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
               && (sum_nxt[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
        sum_fin = sum_nxt[STAGES-1];
`ifdef PIPELINED_ADDER_SAT_EN
        // Both operands share the sign of a, so a's sign tells which rail was crossed.
        if (ovf_nxt) begin
            sum_fin = a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld     <= '0;
            out_vld <= 1'b0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else if (advance) begin
            vld[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld[k] <= vld[k-1];
            end
            out_vld <= vld[STAGES-1];
            sum_o   <= sum_fin;
            cout_o  <= add_res[STAGES-1][C];
            ovf_o   <= ovf_nxt;
        end
    end

    // Datapath carries no reset; validity is tracked entirely by vld/out_vld.
    always_ff @(posedge clk) begin
        if (advance) begin
            a_q[0]   <= bus.a;
            b_q[0]   <= bus.sub ? ~bus.b : bus.b;
            cy_q[0]  <= bus.sub ^ bus.cin;
            sum_q[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                sum_q[k] <= sum_nxt[k-1];
                cy_q[k]  <= add_res[k-1][C];
            end
        end
    end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the single-bit `full_adder`. Adds or subtracts two `WIDTH`-bit operands with carry/borrow-in. The carry chain is split into `STAGES` registered chunks. A valid/ready handshake with backpressure lets the block sit in a datapath between streaming producers and consumers. It reports carry-out and signed overflow per result.

## Interface
- `WIDTH`, 16: operand/result width in bits.
- `STAGES`, 4: pipeline depth.
  - Legal range: 1 ≤ STAGES ≤ WIDTH, with WIDTH % STAGES == 0.
  - Chunk width C = WIDTH/STAGES.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands present.
- `in_ready`  output  1  block can accept operands this cycle.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in (add) / borrow-in (sub).
- `sub`  input  1  0 = add, 1 = subtract.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer accepts result.
- `sum`  output  WIDTH  result.
- `cout`  output  1  carry-out; in sub mode, 1 = no borrow.
- `ovf`  output  1  signed (two's-complement) overflow.

## Operation
- Effective operand: `b_eff = sub ? ~b : b`. Effective carry: `c0 = sub ? ~cin : cin`.
- Result: `{cout, sum} = a + b_eff + c0`, taken modulo 2^(WIDTH+1).
  - Add: a + b + cin.
  - Sub: a − b − cin, mod 2^WIDTH.
- Overflow: `ovf = (a[W-1] == b_eff[W-1]) && (sum_raw[W-1] != a[W-1])`.
- Stage k (0-based) computes result bits [k*C +: C] from:
  - the operand chunks, and
  - the carry registered by stage k−1 (stage 0 uses c0).
- Chunks not yet summed, and chunks already summed, travel in skew registers alongside the stage data.
- Each stage holds a valid bit.
- Global stall: `advance = !out_valid || out_ready`.
  - `in_ready = advance`.
  - When `advance` = 0, every stage register holds, including bubbles.
- Transfer rules:
  - An input is accepted when `in_valid && in_ready` on a rising edge.
  - An output is consumed when `out_valid && out_ready`.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated.
- While `out_valid && !out_ready`:
  - `sum`, `cout` and `ovf` are stable.
  - `in_ready` is 0.
- `in_valid` is a don't-care while `in_ready` = 0. Operands are not sampled.
- `a`/`b`/`cin`/`sub` may change freely between accepted transfers.

## Timing
- Latency: an input accepted at edge N produces `out_valid` = 1 after edge N+STAGES, provided no stall cycles occur.
- Stall: each cycle with `advance` = 0 adds exactly one cycle of latency to every in-flight item.
- Throughput: one result per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid` and `out_ready`. No other input feeds it combinationally.
- Reset:
  - On any edge with `rst` = 1, all stage valid bits clear, so `out_valid` = 0 from the next cycle.
  - `sum`, `cout` and `ovf` reset to 0.
  - In-flight items are discarded.
  - `in_ready` = 1 after reset.
  - `rst` wins over a simultaneous accept; that input is lost.
- `STAGES` = 1: a single registered adder with latency 1.
- Simultaneous output consume and input accept in the same cycle is legal and required at full rate.

## Configuration
- `PIPELINED_ADDER_SAT_EN`
  - Defined: when `ovf` = 1, the final stage clamps `sum` to the signed limit. Positive overflow gives 0x7F..F; negative overflow gives 0x80..0. `cout` and `ovf` are unchanged.
  - Undefined: `sum` is always the wrap-around value.
- Latency is identical in both builds.

## Test plan
All scenarios use WIDTH=16, STAGES=4, `out_ready`=1 unless stated.
- Basic add: a=0x00FF, b=0x0001, cin=0, sub=0 accepted at edge N → `out_valid` after edge N+4, sum=0x0100, cout=0, ovf=0.
- Full carry ripple across all stages: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → ovf=1, cout=0.
  - Without the macro: sum=0x8000.
  - With `PIPELINED_ADDER_SAT_EN`: sum=0x7FFF.
- Subtract with borrow: a=0x0005, b=0x0007, cin=1, sub=1 → sum=0xFFFD, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1, cin=0 → ovf=1, sum=0x7FFF, or 0x8000 with SAT_EN.
- Backpressure: 8 back-to-back inputs a=i, b=i, i=1..8, with `out_ready` low for 3 cycles mid-stream → 8 results 2,4,…,16 in order. `in_ready` = 0 exactly on cycles where `out_valid && !out_ready`. Output is stable while stalled.
- Reset mid-flight: accept 3 items, assert `rst` for 1 cycle → `out_valid` = 0 the next cycle, no stale results ever emerge, and `in_ready` = 1.
